// File: rtl/phase_pkg.sv
// phase_pkg: shared types and defaults for the phase frame controller
package phase_pkg;
    typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;
    localparam int PHASE_W_DEF = 8;
    typedef struct packed {
        logic [PHASE_W_DEF-1:0] phase;
        logic                   en;
    } chan_cfg_t;
endpackage

// File: rtl/phase_shadow_bank.sv
// phase_shadow_bank: shadow and active phase/enable registers with write port and copy strobe
module phase_shadow_bank #(
    parameter int N       = 4,
    parameter int PHASE_W = 8,
    parameter int CH_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_stb,
    input  logic [CH_W-1:0]      wr_idx,
    input  logic [PHASE_W-1:0]   wr_phase,
    input  logic                 wr_en,
    input  logic                 copy,
    output logic [N*PHASE_W-1:0] phases_out,
    output logic [N-1:0]         en_out
);
    logic [N*PHASE_W-1:0] sh_ph_q, sh_ph_d, act_ph_q, act_ph_d;
    logic [N-1:0]         sh_en_q, sh_en_d, act_en_q, act_en_d;

    always_comb begin
        sh_ph_d = sh_ph_q;
        sh_en_d = sh_en_q;
        if (wr_stb) begin
            sh_ph_d[int'(wr_idx)*PHASE_W +: PHASE_W] = wr_phase;
            sh_en_d[wr_idx] = wr_en;
        end
        act_ph_d = copy ? sh_ph_q : act_ph_q;
        act_en_d = copy ? sh_en_q : act_en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_ph_q  <= '0;
            sh_en_q  <= '0;
            act_ph_q <= '0;
            act_en_q <= '0;
        end else begin
            sh_ph_q  <= sh_ph_d;
            sh_en_q  <= sh_en_d;
            act_ph_q <= act_ph_d;
            act_en_q <= act_en_d;
        end
    end

    assign phases_out = act_ph_q;
    assign en_out     = act_en_q;
endmodule

// File: rtl/phase_frame_ctrl.sv
// phase_frame_ctrl: gathers channel writes in a shadow bank and commits them atomically on a PWM period tick
module phase_frame_ctrl
    import phase_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int PHASE_W      = PHASE_W_DEF
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [7:0]                      wr_channel,
    input  logic [PHASE_W-1:0]              wr_phase,
    input  logic                            wr_en,
    input  logic                            commit,
    input  logic                            period_tick,
    output logic [NUM_CHANNELS*PHASE_W-1:0] phases_out,
    output logic [NUM_CHANNELS-1:0]         en_out,
    output logic                            busy,
    output logic                            commit_done,
    output logic                            err_bad_ch,
    output logic [15:0]                     frame_cnt
);
    localparam int CH_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;

    state_t      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [15:0] frame_q, frame_d;
    logic        accept, in_range;

    assign wr_ready = state_q == IDLE;
    assign accept   = wr_valid && wr_ready;
    assign in_range = int'(wr_channel) < NUM_CHANNELS;

    // a tick arriving with the commit itself is ignored: only PENDING watches period_tick
    always_comb begin
        state_d = state_q == IDLE    ? (commit ? PENDING : IDLE) :
                  state_q == PENDING ? (period_tick ? APPLY : PENDING) : IDLE;
        busy_d  = state_d != IDLE;
        done_d  = state_d == APPLY;
        err_d   = accept && !in_range;
        frame_d = state_q == APPLY ? frame_q + 16'd1 : frame_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    phase_shadow_bank #(
        .N       (NUM_CHANNELS),
        .PHASE_W (PHASE_W),
        .CH_W    (CH_W)
    ) u_bank (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .wr_stb     (accept && in_range),
        .wr_idx     (wr_channel[CH_W-1:0]),
        .wr_phase   (wr_phase),
        .wr_en      (wr_en),
        .copy       (state_q == APPLY),
        .phases_out (phases_out),
        .en_out     (en_out)
    );

    assign busy        = busy_q;
    assign commit_done = done_q;
    assign err_bad_ch  = err_q;
    assign frame_cnt   = frame_q;
endmodule

// File: tb/tb_phase_frame_ctrl.sv
// tb_phase_frame_ctrl: directed vector table plus randomized run against a behavioural model
module tb_phase_frame_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst, wr_valid, wr_en, commit, period_tick;
    logic [7:0]  wr_channel, wr_phase;
    logic        wr_ready, busy, commit_done, err_bad_ch;
    logic [31:0] phases_out;
    logic [3:0]  en_out;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    phase_frame_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_channel  (wr_channel),
        .wr_phase    (wr_phase),
        .wr_en       (wr_en),
        .commit      (commit),
        .period_tick (period_tick),
        .phases_out  (phases_out),
        .en_out      (en_out),
        .busy        (busy),
        .commit_done (commit_done),
        .err_bad_ch  (err_bad_ch),
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        logic        rst, v;
        logic [7:0]  ch, ph;
        logic        en, cm, tk;
        logic [31:0] xph;
        logic [3:0]  xen;
        logic        xbusy, xcd, xerr;
        logic [15:0] xfc;
    } vec_t;

    vec_t tbl[32];

    // behavioural model: per-channel arrays and two flags for the commit in flight
    logic [7:0]  m_sh_ph[4], m_act_ph[4];
    logic        m_sh_en[4], m_act_en[4];
    bit          m_waiting, m_applying, m_cd, m_err;
    logic [15:0] m_frames;

    function automatic vec_t mk(logic rst, logic v, logic [7:0] ch, logic [7:0] ph, logic en,
                                logic cm, logic tk, logic [31:0] xph, logic [3:0] xen,
                                logic xbusy, logic xcd, logic xerr, logic [15:0] xfc);
        vec_t r;
        r.rst = rst; r.v = v; r.ch = ch; r.ph = ph; r.en = en; r.cm = cm; r.tk = tk;
        r.xph = xph; r.xen = xen; r.xbusy = xbusy; r.xcd = xcd; r.xerr = xerr; r.xfc = xfc;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic apply(logic rst, logic v, logic [7:0] ch, logic [7:0] ph, logic en, logic cm, logic tk);
        sys_rst = rst; wr_valid = v; wr_channel = ch; wr_phase = ph; wr_en = en;
        commit = cm; period_tick = tk;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_step(logic rst, logic v, logic [7:0] ch, logic [7:0] ph, logic en, logic cm, logic tk);
        bit acc;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_sh_ph[i] = 0; m_sh_en[i] = 0; m_act_ph[i] = 0; m_act_en[i] = 0;
            end
            m_waiting = 0; m_applying = 0; m_frames = 0; m_cd = 0; m_err = 0;
        end else begin
            acc   = v && !(m_waiting || m_applying);
            m_err = acc && ch >= 4;
            m_cd  = 0;
            if (m_applying) begin
                for (int i = 0; i < 4; i++) begin
                    m_act_ph[i] = m_sh_ph[i]; m_act_en[i] = m_sh_en[i];
                end
                m_frames   = m_frames + 16'd1;
                m_applying = 0;
            end else if (m_waiting) begin
                if (tk) begin
                    m_waiting = 0; m_applying = 1; m_cd = 1;
                end
            end else if (cm) begin
                m_waiting = 1;
            end
            if (acc && ch < 4) begin
                m_sh_ph[ch] = ph; m_sh_en[ch] = en;
            end
        end
    endtask

    task automatic model_cycle(logic rst, logic v, logic [7:0] ch, logic [7:0] ph, logic en, logic cm, logic tk);
        logic [31:0] xph;
        logic [3:0]  xen;
        apply(rst, v, ch, ph, en, cm, tk);
        model_step(rst, v, ch, ph, en, cm, tk);
        for (int i = 0; i < 4; i++) begin
            xph[i*8 +: 8] = m_act_ph[i];
            xen[i]        = m_act_en[i];
        end
        check("rnd_phases", phases_out, xph);
        check("rnd_en", 32'(en_out), 32'(xen));
        check("rnd_busy", 32'(busy), 32'(m_waiting || m_applying));
        check("rnd_ready", 32'(wr_ready), 32'(!(m_waiting || m_applying)));
        check("rnd_done", 32'(commit_done), 32'(m_cd));
        check("rnd_err", 32'(err_bad_ch), 32'(m_err));
        check("rnd_frame", 32'(frame_cnt), 32'(m_frames));
    endtask

    initial begin
        sys_rst = 1; wr_valid = 0; wr_channel = 0; wr_phase = 0; wr_en = 0; commit = 0; period_tick = 0;

        //              rst v  ch     ph     en cm tk  phases        en       bsy cd err fc
        tbl[0]  = mk(1, 0, 8'd0, 8'h00, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0, 0, 16'd0);
        tbl[1]  = mk(0, 1, 8'd0, 8'h10, 1, 0, 0, 32'h00000000, 4'b0000, 0, 0, 0, 16'd0);
        tbl[2]  = mk(0, 1, 8'd3, 8'h80, 1, 0, 0, 32'h00000000, 4'b0000, 0, 0, 0, 16'd0);
        tbl[3]  = mk(0, 0, 8'd0, 8'h00, 0, 1, 0, 32'h00000000, 4'b0000, 1, 0, 0, 16'd0);
        tbl[4]  = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h00000000, 4'b0000, 1, 0, 0, 16'd0);
        tbl[5]  = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h00000000, 4'b0000, 1, 0, 0, 16'd0);
        tbl[6]  = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h00000000, 4'b0000, 1, 0, 0, 16'd0);
        tbl[7]  = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h00000000, 4'b0000, 1, 0, 0, 16'd0);
        tbl[8]  = mk(0, 0, 8'd0, 8'h00, 0, 0, 1, 32'h00000000, 4'b0000, 1, 1, 0, 16'd0);
        tbl[9]  = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h80000010, 4'b1001, 0, 0, 0, 16'd1);
        tbl[10] = mk(0, 0, 8'd0, 8'h00, 0, 1, 0, 32'h80000010, 4'b1001, 1, 0, 0, 16'd1);
        tbl[11] = mk(0, 1, 8'd1, 8'h55, 1, 0, 0, 32'h80000010, 4'b1001, 1, 0, 0, 16'd1);
        tbl[12] = mk(0, 1, 8'd1, 8'h55, 1, 0, 1, 32'h80000010, 4'b1001, 1, 1, 0, 16'd1);
        tbl[13] = mk(0, 1, 8'd1, 8'h55, 1, 0, 0, 32'h80000010, 4'b1001, 0, 0, 0, 16'd2);
        tbl[14] = mk(0, 1, 8'd1, 8'h55, 1, 0, 0, 32'h80000010, 4'b1001, 0, 0, 0, 16'd2);
        tbl[15] = mk(0, 0, 8'd0, 8'h00, 0, 1, 0, 32'h80000010, 4'b1001, 1, 0, 0, 16'd2);
        tbl[16] = mk(0, 0, 8'd0, 8'h00, 0, 0, 1, 32'h80000010, 4'b1001, 1, 1, 0, 16'd2);
        tbl[17] = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h80005510, 4'b1011, 0, 0, 0, 16'd3);
        tbl[18] = mk(0, 1, 8'd2, 8'h22, 1, 1, 1, 32'h80005510, 4'b1011, 1, 0, 0, 16'd3);
        tbl[19] = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h80005510, 4'b1011, 1, 0, 0, 16'd3);
        tbl[20] = mk(0, 0, 8'd0, 8'h00, 0, 0, 1, 32'h80005510, 4'b1011, 1, 1, 0, 16'd3);
        tbl[21] = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h80225510, 4'b1111, 0, 0, 0, 16'd4);
        tbl[22] = mk(0, 1, 8'd5, 8'hEE, 0, 0, 0, 32'h80225510, 4'b1111, 0, 0, 1, 16'd4);
        tbl[23] = mk(0, 0, 8'd0, 8'h00, 0, 1, 0, 32'h80225510, 4'b1111, 1, 0, 0, 16'd4);
        tbl[24] = mk(0, 0, 8'd0, 8'h00, 0, 0, 1, 32'h80225510, 4'b1111, 1, 1, 0, 16'd4);
        tbl[25] = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h80225510, 4'b1111, 0, 0, 0, 16'd5);
        tbl[26] = mk(0, 0, 8'd0, 8'h00, 0, 1, 0, 32'h80225510, 4'b1111, 1, 0, 0, 16'd5);
        tbl[27] = mk(1, 0, 8'd0, 8'h00, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0, 0, 16'd0);
        tbl[28] = mk(0, 0, 8'd0, 8'h00, 0, 0, 1, 32'h00000000, 4'b0000, 0, 0, 0, 16'd0);
        tbl[29] = mk(0, 0, 8'd0, 8'h00, 0, 1, 0, 32'h00000000, 4'b0000, 1, 0, 0, 16'd0);
        tbl[30] = mk(0, 0, 8'd0, 8'h00, 0, 0, 1, 32'h00000000, 4'b0000, 1, 1, 0, 16'd0);
        tbl[31] = mk(0, 0, 8'd0, 8'h00, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0, 0, 16'd1);

        for (int i = 0; i < 32; i++) begin
            apply(tbl[i].rst, tbl[i].v, tbl[i].ch, tbl[i].ph, tbl[i].en, tbl[i].cm, tbl[i].tk);
            check($sformatf("vec%0d_phases", i), phases_out, tbl[i].xph);
            check($sformatf("vec%0d_en", i), 32'(en_out), 32'(tbl[i].xen));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].xbusy));
            check($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(!tbl[i].xbusy));
            check($sformatf("vec%0d_done", i), 32'(commit_done), 32'(tbl[i].xcd));
            check($sformatf("vec%0d_err", i), 32'(err_bad_ch), 32'(tbl[i].xerr));
            check($sformatf("vec%0d_frame", i), 32'(frame_cnt), 32'(tbl[i].xfc));
        end

        // frame counter wrap: preload 0xFFFF, then one full commit
        model_cycle(1, 0, 0, 0, 0, 0, 0);
        model_cycle(0, 1, 8'd2, 8'h3C, 1, 0, 0);
        force dut.frame_q = 16'hFFFF;
        #1;
        release dut.frame_q;
        m_frames = 16'hFFFF;
        model_cycle(0, 0, 0, 0, 0, 1, 0);
        model_cycle(0, 0, 0, 0, 0, 0, 1);
        model_cycle(0, 0, 0, 0, 0, 0, 0);
        check("wrap_frame", 32'(frame_cnt), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            model_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                        8'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
                        $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phase_frame_ctrl.md
Name: phase_frame_ctrl

Overview:
- Sits between the command parser in the sys_clk domain and the per-channel PWM phase inputs.
- Collects per-channel phase and enable writes into a shadow bank, then commits the whole bank atomically on the next PWM period boundary, so no transducer sees a half-updated frame.
- Outputs drive the existing pwm_clk two-flop phase synchronizer.
- Also reports commit status and a frame counter back to the host.

Parameters:
- NUM_CHANNELS, 4: number of transducer channels.
- PHASE_W, 8: phase word width per channel.
- CH_W, $clog2(NUM_CHANNELS) (minimum 1): channel index width. Localparam, not overridable.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  synchronous active-high reset.
- wr_valid  in  1  phase write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_channel  in  8  target channel index.
- wr_phase  in  PHASE_W  phase value for the channel.
- wr_en  in  1  channel enable bit.
- commit  in  1  single-cycle pulse requesting a shadow-to-active transfer.
- period_tick  in  1  single-cycle pulse at PWM counter wrap, already synchronized into sys_clk.
- phases_out  out  NUM_CHANNELS*PHASE_W  active phases; channel i occupies bits [i*PHASE_W +: PHASE_W].
- en_out  out  NUM_CHANNELS  active channel enables.
- busy  out  1  high while a commit is pending or being applied.
- commit_done  out  1  single-cycle pulse when the active bank has been updated.
- err_bad_ch  out  1  single-cycle pulse on an accepted write with an out-of-range channel.
- frame_cnt  out  16  count of applied commits.

Behaviour:
- Reset values:
  - shadow and active phases: 0.
  - shadow and active enables: 0, so all channels are off until the first commit.
  - state: IDLE.
  - wr_ready 1; busy, commit_done, err_bad_ch 0; frame_cnt 0.
  - Reset mid-PENDING discards the pending commit and the shadow contents.
- FSM:
  - IDLE:
    - wr_ready = 1.
    - An accepted write updates shadow[wr_channel] at the clock edge.
    - commit moves the FSM to PENDING.
  - PENDING:
    - wr_ready = 0; busy = 1.
    - Waits for period_tick, then moves to APPLY.
    - commit is ignored.
  - APPLY (one cycle):
    - wr_ready = 0; busy = 1.
    - active <= shadow; commit_done = 1 (registered, coincident with the APPLY cycle); frame_cnt <= frame_cnt + 1, wrapping 0xFFFF -> 0.
    - Next state is IDLE.
- Latency: if period_tick is sampled in PENDING at cycle T, the FSM is in APPLY at T+1 and phases_out/en_out show the new values from T+2.
- Simultaneous events:
  - wr accept + commit in IDLE in the same cycle: the write is included in the committed frame.
  - commit + period_tick in IDLE in the same cycle: that tick is not used; the commit waits for the next tick.
  - period_tick in IDLE or APPLY: no effect.
- Out-of-range channel: a write with wr_channel >= NUM_CHANNELS is accepted (handshake completes), the shadow is unchanged, and err_bad_ch pulses on the next cycle.
- Shadow persistence: the shadow keeps its values after a commit. Unwritten channels re-commit their previous values.
- Output timing: active registers drive outputs directly (registered, glitch-free). Outputs hold stable between commits.
- No combinational path from inputs to outputs except wr_ready, which depends on state only.

Decomposition:
- Shared package phase_pkg holds:
  - state enum typedef (IDLE, PENDING, APPLY).
  - PHASE_W default.
  - struct chan_cfg_t {phase, en}.
- Natural sub-module: phase_shadow_bank, which holds the shadow/active register arrays with write port and copy strobe. The FSM stays in phase_frame_ctrl.

Test Plan:
- Reset -> phases_out all 0, en_out 4'b0000, wr_ready 1, busy 0, frame_cnt 0.
- Write ch0=0x10/en1, ch3=0x80/en1, commit, period_tick 5 cycles later -> outputs unchanged until 2 cycles after the tick; then ch0=0x10, ch3=0x80, en_out 4'b1001; commit_done 1 pulse; frame_cnt 1.
- While PENDING, assert wr_valid ch1=0x55 -> wr_ready 0, no shadow change. After APPLY the write is accepted; a second commit yields ch1=0x55.
- Write ch2=0x22 and commit in the same cycle, with period_tick also in that cycle -> no apply on that tick; applies on the next tick with ch2=0x22 included.
- Write wr_channel=5 -> handshake completes, err_bad_ch pulse, shadow unchanged; committed outputs match prior values.
- Assert sys_rst while PENDING -> outputs return to reset values; a subsequent period_tick produces no commit_done.
- Preload frame_cnt to 0xFFFF via 65535 commits (or force) -> the next commit gives frame_cnt 0x0000.
